// File: rtl/countdown_bcd_display.sv
// Game countdown timer: DIGITS-wide BCD down-counter with start/pause/load
// control, low-time flash and game-over flags, and seven-segment outputs.
module countdown_bcd_display #(
    parameter int                  DIGITS        = 2,
    parameter logic [4*DIGITS-1:0] START_BCD     = 8'h30,
    parameter logic [4*DIGITS-1:0] WARN_BCD      = 8'h10,
    parameter bit                  BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    output logic [4*DIGITS-1:0]   bcd_value,
    output logic                  running,
    output logic                  warning,
    output logic                  game_finished,
    output logic                  finished_pulse,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, FINISHED} state_t;

    state_t          state;
    state_t          state_nx;
    logic [BW-1:0]   count_nx;
    logic            tick_used;
    logic            warn_nx;
    logic            flash_phase;
    logic            flash_nx;

    function automatic logic [BW-1:0] clamp_bcd(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Ripple borrow from digit 0 upward; only called with a nonzero count.
    function automatic logic [BW-1:0] dec_bcd(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Scan from the top digit so "lead" stays set only while every digit seen so far is zero.
    function automatic logic [SW-1:0] render(input logic [BW-1:0] v, input logic blank_all);
        logic [SW-1:0] r;
        logic          lead;
        lead = 1'b1;
        r    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead = lead && (v[4*i +: 4] == 4'd0);
            if (blank_all || (BLANK_LEADING && (i > 0) && lead))
                r[7*i +: 7] = 7'h7F;
            else
                r[7*i +: 7] = seg7(v[4*i +: 4]);
        end
        return r;
    endfunction

    always_comb begin
        state_nx  = state;
        count_nx  = bcd_value;
        tick_used = 1'b0;
        if (load && (state != RUNNING)) begin
            count_nx = clamp_bcd(load_bcd);
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_nx = (bcd_value == '0) ? FINISHED : RUNNING;
                end
                RUNNING: begin
                    if (pause) begin
                        state_nx = PAUSED;
                    end else if (tick) begin
                        count_nx  = dec_bcd(bcd_value);
                        tick_used = 1'b1;
                        if (count_nx == '0) state_nx = FINISHED;
                    end
                end
                PAUSED: begin
                    if (start && !pause) state_nx = RUNNING;
                end
                default: ;
            endcase
        end
        warn_nx  = (state_nx == RUNNING) && (count_nx != '0) && (count_nx <= WARN_BCD);
        flash_nx = warn_nx && (flash_phase ^ tick_used);
    end

    // Stage 0: state, count and flags; stage 1: display encode from stage-0 registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            bcd_value      <= clamp_bcd(START_BCD);
            flash_phase    <= 1'b0;
            running        <= 1'b0;
            warning        <= 1'b0;
            game_finished  <= 1'b0;
            finished_pulse <= 1'b0;
            hex            <= render(clamp_bcd(START_BCD), 1'b0);
        end else begin
            state          <= state_nx;
            bcd_value      <= count_nx;
            flash_phase    <= flash_nx;
            running        <= (state_nx == RUNNING);
            warning        <= warn_nx;
            game_finished  <= (state_nx == FINISHED);
            finished_pulse <= (state_nx == FINISHED) && (state != FINISHED);
            hex            <= render(bcd_value, flash_phase);
        end
    end

endmodule

// File: tb/tb_countdown_bcd_display.sv
// Bench for countdown_bcd_display: vector table on a 2-digit instance with a
// hex scoreboard for the one-cycle display lag, plus 3-digit borrow/clamp sequences.
module tb_countdown_bcd_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, tick, start, pause, load;
    logic [7:0]  load_bcd, bcd_value;
    logic        running, warning, game_finished, finished_pulse;
    logic [13:0] hex;

    logic        rst3_n, tick3, start3, pause3, load3;
    logic [11:0] load_bcd3, bcd3;
    logic        run3, warn3, fin3, fp3;
    logic [20:0] hex3;

    countdown_bcd_display #(
        .DIGITS(2), .START_BCD(8'h30), .WARN_BCD(8'h10), .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause(pause),
        .load(load), .load_bcd(load_bcd), .bcd_value(bcd_value),
        .running(running), .warning(warning), .game_finished(game_finished),
        .finished_pulse(finished_pulse), .hex(hex)
    );

    countdown_bcd_display #(
        .DIGITS(3), .START_BCD(12'h030), .WARN_BCD(12'h010), .BLANK_LEADING(1'b1)
    ) dut3 (
        .clk(clk), .rst_n(rst3_n), .tick(tick3), .start(start3), .pause(pause3),
        .load(load3), .load_bcd(load_bcd3), .bcd_value(bcd3),
        .running(run3), .warning(warn3), .game_finished(fin3),
        .finished_pulse(fp3), .hex(hex3)
    );

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
    localparam logic [6:0] BL = 7'h7F;

    // Control word {rst_n, tick, start, pause, load}
    localparam logic [4:0] C_RST = 5'b00000, C_NOP = 5'b10000, C_TICK = 5'b11000;
    localparam logic [4:0] C_START = 5'b10100, C_PAUSE = 5'b10010, C_LOAD = 5'b10001;

    typedef struct {
        logic [4:0]  ctl;
        logic [7:0]  ld;
        logic [7:0]  bcd;
        logic [3:0]  flg;   // {running, warning, game_finished, finished_pulse}
        logic [13:0] hex;   // display expected one cycle after this step
    } vec_t;

    vec_t        vt[$];
    vec_t        v;
    logic [13:0] hq[$];
    int          checks   = 0;
    int          failures = 0;

    function automatic vec_t V(input logic [4:0] c, input logic [7:0] ld, input logic [7:0] b,
                               input logic [3:0] f, input logic [6:0] h1, input logic [6:0] h0);
        vec_t r;
        r.ctl = c; r.ld = ld; r.bcd = b; r.flg = f; r.hex = {h1, h0};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        {rst_n, tick, start, pause, load} = C_RST;
        load_bcd = 8'h00;
        {rst3_n, tick3, start3, pause3, load3} = 5'b00000;
        load_bcd3 = 12'h000;

        vt.push_back(V(C_RST,            8'h00, 8'h30, 4'b0000, S3, S0));
        vt.push_back(V(C_START,          8'h00, 8'h30, 4'b1000, S3, S0));
        vt.push_back(V(C_TICK,           8'h00, 8'h29, 4'b1000, S2, S9));
        vt.push_back(V(C_NOP,            8'h00, 8'h29, 4'b1000, S2, S9));
        vt.push_back(V(C_PAUSE,          8'h00, 8'h29, 4'b0000, S2, S9));
        vt.push_back(V(C_PAUSE | C_LOAD, 8'h17, 8'h17, 4'b0000, S1, S7));
        vt.push_back(V(C_START,          8'h00, 8'h17, 4'b1000, S1, S7));
        vt.push_back(V(C_TICK | C_PAUSE, 8'h00, 8'h17, 4'b0000, S1, S7));
        for (int i = 0; i < 3; i++)
            vt.push_back(V(C_TICK | C_PAUSE, 8'h00, 8'h17, 4'b0000, S1, S7));
        vt.push_back(V(C_TICK | C_PAUSE | C_START, 8'h00, 8'h17, 4'b0000, S1, S7));
        vt.push_back(V(C_START,          8'h00, 8'h17, 4'b1000, S1, S7));
        vt.push_back(V(C_TICK,           8'h00, 8'h16, 4'b1000, S1, S6));
        vt.push_back(V(C_TICK,           8'h00, 8'h15, 4'b1000, S1, S5));
        vt.push_back(V(C_TICK,           8'h00, 8'h14, 4'b1000, S1, S4));
        vt.push_back(V(C_TICK,           8'h00, 8'h13, 4'b1000, S1, S3));
        vt.push_back(V(C_TICK,           8'h00, 8'h12, 4'b1000, S1, S2));
        vt.push_back(V(C_RST | 5'b01000, 8'h00, 8'h30, 4'b0000, S3, S0));
        vt.push_back(V(C_TICK,           8'h00, 8'h30, 4'b0000, S3, S0));
        vt.push_back(V(C_LOAD,           8'h11, 8'h11, 4'b0000, S1, S1));
        vt.push_back(V(C_START,          8'h00, 8'h11, 4'b1000, S1, S1));
        vt.push_back(V(C_TICK,           8'h00, 8'h10, 4'b1100, BL, BL));
        vt.push_back(V(C_TICK,           8'h00, 8'h09, 4'b1100, BL, S9));
        vt.push_back(V(C_TICK,           8'h00, 8'h08, 4'b1100, BL, BL));
        vt.push_back(V(C_TICK,           8'h00, 8'h07, 4'b1100, BL, S7));
        vt.push_back(V(C_TICK,           8'h00, 8'h06, 4'b1100, BL, BL));
        vt.push_back(V(C_TICK,           8'h00, 8'h05, 4'b1100, BL, S5));
        vt.push_back(V(C_TICK,           8'h00, 8'h04, 4'b1100, BL, BL));
        vt.push_back(V(C_TICK,           8'h00, 8'h03, 4'b1100, BL, S3));
        vt.push_back(V(C_TICK,           8'h00, 8'h02, 4'b1100, BL, BL));
        vt.push_back(V(C_TICK,           8'h00, 8'h01, 4'b1100, BL, S1));
        vt.push_back(V(C_TICK,           8'h00, 8'h00, 4'b0011, BL, S0));
        vt.push_back(V(C_TICK,           8'h00, 8'h00, 4'b0010, BL, S0));
        vt.push_back(V(C_TICK | C_START, 8'h00, 8'h00, 4'b0010, BL, S0));
        vt.push_back(V(C_TICK,           8'h00, 8'h00, 4'b0010, BL, S0));
        vt.push_back(V(C_LOAD,           8'h05, 8'h05, 4'b0000, BL, S5));
        vt.push_back(V(C_START,          8'h00, 8'h05, 4'b1100, BL, S5));
        vt.push_back(V(C_TICK,           8'h00, 8'h04, 4'b1100, BL, BL));
        vt.push_back(V(C_TICK,           8'h00, 8'h03, 4'b1100, BL, S3));
        vt.push_back(V(C_TICK,           8'h00, 8'h02, 4'b1100, BL, BL));
        vt.push_back(V(C_TICK,           8'h00, 8'h01, 4'b1100, BL, S1));
        vt.push_back(V(C_TICK,           8'h00, 8'h00, 4'b0011, BL, S0));
        vt.push_back(V(C_NOP,            8'h00, 8'h00, 4'b0010, BL, S0));
        vt.push_back(V(C_LOAD,           8'h00, 8'h00, 4'b0000, BL, S0));
        vt.push_back(V(C_START,          8'h00, 8'h00, 4'b0011, BL, S0));
        vt.push_back(V(C_NOP,            8'h00, 8'h00, 4'b0010, BL, S0));
        vt.push_back(V(C_LOAD,           8'h20, 8'h20, 4'b0000, S2, S0));
        vt.push_back(V(C_START,          8'h00, 8'h20, 4'b1000, S2, S0));
        vt.push_back(V(C_PAUSE,          8'h00, 8'h20, 4'b0000, S2, S0));
        vt.push_back(V(C_LOAD | C_START, 8'h33, 8'h33, 4'b0000, S3, S3));
        vt.push_back(V(C_TICK | C_START, 8'h00, 8'h33, 4'b1000, S3, S3));
        vt.push_back(V(C_LOAD | C_TICK,  8'h12, 8'h32, 4'b1000, S3, S2));
        vt.push_back(V(C_PAUSE,          8'h00, 8'h32, 4'b0000, S3, S2));
        vt.push_back(V(C_LOAD,           8'hAF, 8'h99, 4'b0000, S9, S9));
        vt.push_back(V(C_NOP,            8'h00, 8'h99, 4'b0000, S9, S9));

        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            {rst_n, tick, start, pause, load} = v.ctl;
            load_bcd = v.ld;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d bcd_value", i), {24'd0, bcd_value}, {24'd0, v.bcd});
            chk($sformatf("v%0d flags", i),
                {28'd0, running, warning, game_finished, finished_pulse}, {28'd0, v.flg});
            if (!v.ctl[4]) begin
                hq.delete();
                chk($sformatf("v%0d hex_reset", i), {18'd0, hex}, {18'd0, v.hex});
            end else if (hq.size() > 0) begin
                chk($sformatf("v%0d hex", i), {18'd0, hex}, {18'd0, hq.pop_front()});
            end
            hq.push_back(v.hex);
            @(negedge clk);
        end
        {rst_n, tick, start, pause, load} = C_NOP;

        // Three-digit instance: reset, double borrow, blanking, clamp.
        @(posedge clk); #1;
        chk("d3 reset bcd", {20'd0, bcd3}, 32'h030);
        chk("d3 reset hex", {11'd0, hex3}, {11'd0, BL, S3, S0});
        chk("d3 reset flags", {28'd0, run3, warn3, fin3, fp3}, 32'h0);
        rst3_n = 1'b1; load3 = 1'b1; load_bcd3 = 12'h100;
        @(posedge clk); #1;
        chk("d3 load100 bcd", {20'd0, bcd3}, 32'h100);
        load3 = 1'b0; start3 = 1'b1;
        @(posedge clk); #1;
        chk("d3 start run", {31'd0, run3}, 32'd1);
        chk("d3 hex100", {11'd0, hex3}, {11'd0, S1, S0, S0});
        start3 = 1'b0; tick3 = 1'b1;
        @(posedge clk); #1;
        chk("d3 borrow bcd", {20'd0, bcd3}, 32'h099);
        chk("d3 borrow warn", {31'd0, warn3}, 32'd0);
        tick3 = 1'b0;
        @(posedge clk); #1;
        chk("d3 hex099", {11'd0, hex3}, {11'd0, BL, S9, S9});
        pause3 = 1'b1;
        @(posedge clk); #1;
        load3 = 1'b1; load_bcd3 = 12'hAF5;
        @(posedge clk); #1;
        chk("d3 clamp bcd", {20'd0, bcd3}, 32'h995);
        chk("d3 clamp run", {31'd0, run3}, 32'd0);
        load3 = 1'b1; load_bcd3 = 12'h005; pause3 = 1'b0;
        @(posedge clk); #1;
        chk("d3 hex995", {11'd0, hex3}, {11'd0, S9, S9, S5});
        load3 = 1'b0;
        @(posedge clk); #1;
        chk("d3 hex005", {11'd0, hex3}, {11'd0, BL, BL, S5});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
